// File: rtl/div_pkg.sv
// Shared divider constants and widths, also used by the execute stage.
// Optional build macro: DIV_EARLY_OUT_EN (see rtl/div.sv).
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    function automatic logic [RegBus-1:0] neg(input logic [RegBus-1:0] v);
        return (~v) + RegBus'(1);
    endfunction

    function automatic logic [RegBus-1:0] mag(input logic sgn,
                                              input logic [RegBus-1:0] v);
        return (sgn && v[RegBus-1]) ? neg(v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// partial remainder shifted left with the next dividend bit.
module div_step
    import div_pkg::*;
(
    input  logic [RegBus-1:0] r,
    input  logic              nbit,
    input  logic [RegBus-1:0] b,
    output logic [RegBus-1:0] r_next,
    output logic              q_bit
);

    logic [RegBus:0] trial;

    assign trial  = {r, nbit} - {1'b0, b};
    assign q_bit  = ~trial[RegBus];
    // r < b always holds, so the failed-trial value fits in RegBus bits
    assign r_next = q_bit ? trial[RegBus-1:0] : {r[RegBus-2:0], nbit};

endmodule

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, with annul support.
// Define DIV_EARLY_OUT_EN to finish at once when |dividend| < |divisor|.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    logic [1:0]        state;
    logic [5:0]        cnt;
    logic [RegBus-1:0] rem;
    logic [RegBus-1:0] quo;
    logic [RegBus-1:0] dvsr;
    logic              neg_q;
    logic              neg_r;
    logic [RegBus-1:0] step_r;
    logic              step_q;
    logic [RegBus-1:0] fix_q;
    logic [RegBus-1:0] fix_r;
    logic [RegBus-1:0] fix_a;
    logic              early;

    div_step u_step (
        .r      (rem),
        .nbit   (quo[RegBus-1]),
        .b      (dvsr),
        .r_next (step_r),
        .q_bit  (step_q)
    );

    assign fix_q = neg_q ? neg(quo) : quo;
    assign fix_r = neg_r ? neg(rem) : rem;
    // quo still holds |dividend| on the first DivOn cycle
    assign fix_a = neg_r ? neg(quo) : quo;

`ifdef DIV_EARLY_OUT_EN
    assign early = (cnt == 6'd0) && (quo < dvsr);
`else
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else if (annul_i) begin
            state    <= DivFree;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            unique case (state)
                DivFree: begin
                    if (start_i == DivStart) begin
                        if (opdata2_i == '0) begin
                            state <= DivByZero;
                        end else begin
                            state <= DivOn;
                            cnt   <= '0;
                            rem   <= '0;
                            quo   <= mag(signed_div_i, opdata1_i);
                            dvsr  <= mag(signed_div_i, opdata2_i);
                            neg_q <= signed_div_i &
                                     (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
                            neg_r <= signed_div_i & opdata1_i[RegBus-1];
                        end
                    end
                end
                DivByZero: begin
                    state    <= DivEnd;
                    result_o <= '0;
                    ready_o  <= DivResultReady;
                end
                DivOn: begin
                    if (early) begin
                        state    <= DivEnd;
                        result_o <= {fix_a, {RegBus{1'b0}}};
                        ready_o  <= DivResultReady;
                    end else if (cnt != 6'd32) begin
                        rem <= step_r;
                        quo <= {quo[RegBus-2:0], step_q};
                        cnt <= cnt + 6'd1;
                    end else begin
                        state    <= DivEnd;
                        result_o <= {fix_r, fix_q};
                        ready_o  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state    <= DivFree;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: driver queues expected {rem, quo} and ready cycle,
// a negedge monitor pops and compares whenever ready_o rises.
module tb_div;
    import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int EarlyLat = 2;
`else
    localparam int EarlyLat = 34;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          at;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [63:0] held = '0;
    logic        was_ready = 1'b0;
    int          checks = 0;
    int          fails = 0;

    always @(negedge clk) begin
        if (ready_o && !was_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ready result=%h", result_o);
            end else begin
                cur = sb.pop_front();
                held = cur.res;
                checks++;
                if (result_o !== cur.res) begin
                    fails++;
                    $display("FAIL %s result got=%h exp=%h", cur.name, result_o, cur.res);
                end
                checks++;
                if (cyc != cur.at) begin
                    fails++;
                    $display("FAIL %s latency ready_cycle got=%0d exp=%0d",
                             cur.name, cyc, cur.at);
                end
            end
        end else if (ready_o) begin
            checks++;
            if (result_o !== held) begin
                fails++;
                $display("FAIL hold_stable result got=%h exp=%h", result_o, held);
            end
        end
        was_ready <= ready_o;
    end

    task automatic expect_idle(input string name);
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            fails++;
            $display("FAIL %s ready=%b result=%h exp ready=0 result=0",
                     name, ready_o, result_o);
        end
    endtask

    task automatic wait_ready(input string name, output bit got);
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (ready_o) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL %s timeout ready=%b exp=1", name, ready_o);
        end
    endtask

    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res, input int lat, input int hold,
                       input string name);
        bit got;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i = 1'b1;
        sb.push_back('{exp_res, cyc + lat, name});
        @(negedge clk);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~sgn;
        wait_ready(name, got);
        if (got) repeat (hold) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        expect_idle({name, "_stop"});
    endtask

    initial begin
        bit got;
        repeat (2) @(negedge clk);
        expect_idle("reset_state");
        rst = 1'b1;
        @(negedge clk);
        expect_idle("post_reset");

        run(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 0, "u100_7");
        run(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 0, "s_m7_2");
        run(1'b1, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 34, 0, "s100_m7");
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34, 0, "s_min_m1");
        run(1'b1, 32'd5, 32'd0, 64'd0, 2, 0, "s5_0");
        run(1'b0, 32'd5, 32'd0, 64'd0, 2, 0, "u5_0");
        run(1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, EarlyLat, 3, "u3_10_hold");
        run(1'b1, 32'hFFFF_FFFD, 32'd10, {32'hFFFF_FFFD, 32'd0}, EarlyLat, 0, "s_m3_10");
        run(1'b1, 32'd0, 32'd5, 64'd0, EarlyLat, 0, "s0_5");

        // annul mid-iteration: no result may appear
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'hFFFF_FFFF;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        expect_idle("annul_clear");
        repeat (40) @(negedge clk);
        expect_idle("annul_quiet");
        run(1'b0, 32'hFFFF_FFFF, 32'd3, {32'd0, 32'h5555_5555}, 34, 0, "u_ffff_3");

        // reset while result is presented: outputs clear asynchronously
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        sb.push_back('{{32'd2, 32'd14}, cyc + 34, "u100_7_rst"});
        @(negedge clk);
        wait_ready("u100_7_rst", got);
        #2 rst = 1'b0;
        #1 expect_idle("rst_async_end");
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // reset at iteration 20
        @(negedge clk);
        opdata1_i = 32'hFFFF_FFFF;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        start_i = 1'b0;
        #1 expect_idle("rst_mid_op");
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        expect_idle("rst_quiet");
        run(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 0, "u9_3");

        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
